// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and access-size helper for the load/store memory port.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // RW_type bit that selects zero-extension on loads
  localparam int unsigned UNS_BIT = 2;

  // Access type used for every piece of a split (misaligned) transfer
  localparam logic [2:0] RW_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of right-aligned load data according to RW_type.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        rw_type,
  output logic [DATA_W-1:0] ext
);

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [2:0]        t);
    logic signed [7:0]        b_s;
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] w_s;
    b_s = d[7:0];
    h_s = d[15:0];
    w_s = '0;
    case (t[1:0])
      SZ_BYTE: begin
        if (t[UNS_BIT]) w_s = {{(DATA_W-8){1'b0}}, d[7:0]};
        else            w_s = DATA_W'(b_s);
      end
      SZ_HALF: begin
        if (t[UNS_BIT]) w_s = {{(DATA_W-16){1'b0}}, d[15:0]};
        else            w_s = DATA_W'(h_s);
      end
      SZ_WORD: w_s = d;
      default: w_s = '0;
    endcase
    extend = w_s;
  endfunction

  assign ext = extend(data, rw_type);

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the combinational-read, clocked-write memory port.
// Optional build macro MISALIGN_SPLIT_EN: byte-split misaligned accesses instead of faulting them.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_W_en,
  output logic              mem_R_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_RW_type,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  lsu_state_e        state, state_nxt;
  logic              we_p0;
  logic [2:0]        type_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [ADDR_W-1:0] ptr_p0;
  logic              fault_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic [DATA_W-1:0] rdata_ext;
  logic              accept;
  logic              req_mis;
  logic              req_illegal;
  logic              last_acc;
`ifdef MISALIGN_SPLIT_EN
  logic              split_p0;
  logic [1:0]        cnt_p0;
`endif

  assign accept  = (state == ST_IDLE) && req_valid;
  assign req_mis = ((req_type[1:0] == SZ_HALF) && req_addr[0]) ||
                   ((req_type[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MISALIGN_SPLIT_EN
  assign req_illegal = (req_type[1:0] == SZ_ILL);
  assign last_acc    = !split_p0 || ({1'b0, cnt_p0} == (size_bytes(type_p0[1:0]) - 3'd1));
`else
  assign req_illegal = (req_type[1:0] == SZ_ILL) || req_mis;
  assign last_acc    = 1'b1;
`endif

  // Stage p0: request capture, address pointer and load-data assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      we_p0    <= 1'b0;
      type_p0  <= '0;
      wdata_p0 <= '0;
      ptr_p0   <= '0;
      fault_p0 <= 1'b0;
      rdata_p1 <= '0;
`ifdef MISALIGN_SPLIT_EN
      split_p0 <= 1'b0;
      cnt_p0   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_p0    <= req_we;
        type_p0  <= req_type;
        wdata_p0 <= req_wdata;
        ptr_p0   <= req_addr;
        fault_p0 <= req_illegal;
        rdata_p1 <= '0;
`ifdef MISALIGN_SPLIT_EN
        split_p0 <= req_mis;
        cnt_p0   <= '0;
`endif
      end else if (state == ST_ACC) begin
`ifdef MISALIGN_SPLIT_EN
        if (split_p0) begin
          if (!we_p0) rdata_p1[{cnt_p0, 3'b000} +: 8] <= mem_dout[7:0];
          ptr_p0 <= ptr_p0 + ADDR_W'(1);
          cnt_p0 <= cnt_p0 + 2'd1;
        end else if (!we_p0) begin
          rdata_p1 <= mem_dout;
        end
`else
        if (!we_p0) rdata_p1 <= mem_dout;
`endif
      end
    end
  end

  // Next state and all port outputs; memory side is only live in ACC
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    resp_valid  = 1'b0;
    resp_fault  = 1'b0;
    resp_rdata  = '0;
    mem_W_en    = 1'b0;
    mem_R_en    = 1'b0;
    mem_addr    = '0;
    mem_RW_type = '0;
    mem_din     = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_nxt = req_illegal ? ST_RESP : ST_ACC;
      end
      ST_ACC: begin
        mem_W_en    = we_p0;
        mem_R_en    = !we_p0;
        mem_addr    = ptr_p0;
        mem_RW_type = type_p0;
        mem_din     = wdata_p0;
`ifdef MISALIGN_SPLIT_EN
        if (split_p0) begin
          mem_RW_type = RW_BYTE_U;
          mem_din     = {{(DATA_W-8){1'b0}}, wdata_p0[{cnt_p0, 3'b000} +: 8]};
        end
`endif
        if (last_acc) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_p0;
        if (!we_p0 && !fault_p0) resp_rdata = rdata_ext;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  lsu_load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .data    (rdata_p1),
    .rw_type (type_p0),
    .ext     (rdata_ext)
  );

endmodule
